// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter between the pipeline writeback and the
// multdiv unit. One multdiv result can be buffered while the pipeline owns the
// port; a starvation counter forces the buffered result through by stalling
// the pipeline. Writes appear on rf_we/rf_wdata one cycle after they are granted.
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic [31:0] rf_we,
    output logic [31:0] rf_wdata,
    output logic        md_pending,
    output logic [4:0]  md_pending_rd,
    output logic        pipe_stall
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [4:0]  buf_rd_q, buf_rd_d;
    logic [31:0] buf_data_q, buf_data_d;

    logic        grant;
    logic [4:0]  grant_rd;
    logic [31:0] grant_data;
    logic [31:0] we_d;
    logic [31:0] wdata_d;

    assign md_ready      = (state_q == IDLE);
    assign md_pending    = (state_q == HOLD);
    // The buffer is cleared whenever HOLD is left, so it already reads 0 in IDLE.
    assign md_pending_rd = buf_rd_q;
    assign pipe_stall    = (state_q == HOLD) && (cnt_q == LIMIT);

    // Next-state, buffer/counter update and write-port grant selection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        grant      = 1'b0;
        grant_rd   = '0;
        grant_data = '0;

        unique case (state_q)
            IDLE: begin
                if (pipe_we) begin
                    grant      = 1'b1;
                    grant_rd   = pipe_rd;
                    grant_data = pipe_data;
                    // Same destination: the younger pipeline write wins and
                    // the multdiv result is simply dropped.
                    if (md_valid && (md_rd != pipe_rd)) begin
                        buf_rd_d   = md_rd;
                        buf_data_d = md_data;
                        cnt_d      = '0;
                        state_d    = HOLD;
                    end
                end else if (md_valid) begin
                    grant      = 1'b1;
                    grant_rd   = md_rd;
                    grant_data = md_data;
                end
            end
            HOLD: begin
                if (pipe_stall || !pipe_we) begin
                    grant      = 1'b1;
                    grant_rd   = buf_rd_q;
                    grant_data = buf_data_q;
                    buf_rd_d   = '0;
                    buf_data_d = '0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    grant      = 1'b1;
                    grant_rd   = pipe_rd;
                    grant_data = pipe_data;
                    if (pipe_rd == buf_rd_q) begin
                        buf_rd_d   = '0;
                        buf_data_d = '0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else if (cnt_q != LIMIT) begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode the grant into a one-hot enable; register 0 is never written.
    always_comb begin
        we_d    = '0;
        wdata_d = '0;
        if (grant && (grant_rd != 5'd0)) begin
            we_d[grant_rd] = 1'b1;
            wdata_d        = grant_data;
        end
    end

    // State, buffer, counter and registered write-port outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            rf_we      <= '0;
            rf_wdata   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            rf_we      <= we_d;
            rf_wdata   <= wdata_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: each stimulus cycle pushes the
// expected registered write; a monitor pops and compares on every falling edge.
module tb_rf_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_rd = '0;
    logic [31:0] md_data = '0;
    logic        md_ready;
    logic [31:0] rf_we;
    logic [31:0] rf_wdata;
    logic        md_pending;
    logic [4:0]  md_pending_rd;
    logic        pipe_stall;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] we;
        logic [31:0] wd;
    } exp_t;
    exp_t sb_q[$];

    rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock),
        .reset(reset),
        .pipe_we(pipe_we),
        .pipe_rd(pipe_rd),
        .pipe_data(pipe_data),
        .md_valid(md_valid),
        .md_rd(md_rd),
        .md_data(md_data),
        .md_ready(md_ready),
        .rf_we(rf_we),
        .rf_wdata(rf_wdata),
        .md_pending(md_pending),
        .md_pending_rd(md_pending_rd),
        .pipe_stall(pipe_stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: registered write outputs are compared once per cycle.
    always @(negedge clock) begin
        if (!reset && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rf_we", rf_we, e.we);
            chk("rf_wdata", rf_wdata, e.wd);
        end
    end

    // One cycle: drive inputs, check combinational/status outputs, clock,
    // then queue the write expected on the outputs after that edge.
    task automatic step(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic [31:0] e_we, input logic [31:0] e_wd,
                        input logic e_rdy, input logic e_stall,
                        input logic e_pend, input logic [4:0] e_prd);
        exp_t e;
        pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
        md_valid = mv; md_rd = mrd; md_data = md;
        #2;
        chk("md_ready", 32'(md_ready), 32'(e_rdy));
        chk("pipe_stall", 32'(pipe_stall), 32'(e_stall));
        chk("md_pending", 32'(md_pending), 32'(e_pend));
        chk("md_pending_rd", 32'(md_pending_rd), 32'(e_prd));
        @(posedge clock);
        e.we = e_we;
        e.wd = e_wd;
        sb_q.push_back(e);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_rf_we", rf_we, 32'h0);
        chk("rst_rf_wdata", rf_wdata, 32'h0);
        chk("rst_md_ready", 32'(md_ready), 32'h1);
        chk("rst_md_pending", 32'(md_pending), 32'h0);
        chk("rst_pipe_stall", 32'(pipe_stall), 32'h0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        // Idle md write to r5
        step(0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h20, 32'hDEADBEEF, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
        // Conflict then drain; md inputs offered while busy are ignored
        step(1, 3, 32'h11, 1, 7, 32'h22, 32'h8, 32'h11, 1, 0, 0, 0);
        step(0, 0, 0, 1, 12, 32'h99, 32'h80, 32'h22, 0, 0, 1, 7);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
        // Starvation with limit 4
        step(1, 2, 32'hA1, 1, 9, 32'hB2, 32'h4, 32'hA1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(1, 2, 32'hC0 + 32'(i), 0, 0, 0, 32'h4, 32'hC0 + 32'(i), 0, 0, 1, 9);
        step(1, 2, 32'hEE, 0, 0, 0, 32'h200, 32'hB2, 0, 1, 1, 9);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
        // WAW supersede of buffered r4
        step(1, 1, 32'h31, 1, 4, 32'h44, 32'h2, 32'h31, 1, 0, 0, 0);
        step(1, 4, 32'h55, 0, 0, 0, 32'h10, 32'h55, 0, 0, 1, 4);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
        // Register 0 writes are dropped
        step(1, 0, 32'h77, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h78, 32'h0, 32'h0, 1, 0, 0, 0);
        step(1, 0, 32'h79, 1, 6, 32'h66, 32'h0, 32'h0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h40, 32'h66, 0, 0, 1, 6);
        // Same-destination conflict in IDLE drops the md result
        step(1, 10, 32'hAA, 1, 10, 32'hBB, 32'h400, 32'hAA, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
        // Async reset while holding r8
        step(1, 5, 32'h1, 1, 8, 32'h2, 32'h20, 32'h1, 1, 0, 0, 0);
        @(negedge clock); #1;
        chk("pre_rst_md_pending", 32'(md_pending), 32'h1);
        reset = 1'b1;
        #1;
        chk("arst_md_pending", 32'(md_pending), 32'h0);
        chk("arst_md_pending_rd", 32'(md_pending_rd), 32'h0);
        chk("arst_rf_we", rf_we, 32'h0);
        chk("arst_pipe_stall", 32'(pipe_stall), 32'h0);
        chk("arst_md_ready", 32'(md_ready), 32'h1);
        pipe_we = 1'b0; md_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 32'h3, 32'h2, 32'h3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);

        @(negedge clock); #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
